// File: rtl/fpu_mul_arbiter.sv
// fpu_mul_arbiter: shares one FP32 multiplier between NREQ requesters.
// Round-robin grant, one operation in flight, result held until the
// consumer accepts it. Data passes through bit-exact.
module fpu_mul_arbiter #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int MUL_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [31:0]       resp_data,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_op,
    output logic              busy
);

    localparam int CNTW = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [CNTW-1:0]  cnt_q;
    logic [31:0]      mul_a_q;
    logic [31:0]      mul_b_q;
    logic [31:0]      resp_data_q;
    logic [IDW-1:0]   resp_id_q;
    logic             resp_valid_q;

    logic [2*NREQ-1:0] rot_wide;
    logic [NREQ-1:0]   rot_valid;
    logic              any_req;
    logic [IDW-1:0]    grant_idx;
    logic [NREQ-1:0]   grant_oh;
    logic [IDW:0]      idx_sum;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic [IDW-1:0]    ptr_d;

    // Round-robin search: rotate req_valid so bit k is requester (ptr+k) mod NREQ,
    // then take the first set bit and map it back to a requester index.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        rot_wide  = {req_valid, req_valid} >> ptr_q;
        rot_valid = rot_wide[NREQ-1:0];
        any_req   = 1'b0;
        grant_idx = '0;
        idx_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && rot_valid[k]) begin
                any_req = 1'b1;
                idx_sum = {1'b0, ptr_q} + (IDW+1)'(k);
                if (idx_sum >= (IDW+1)'(NREQ)) begin
                    idx_sum = idx_sum - (IDW+1)'(NREQ);
                end
                grant_idx = idx_sum[IDW-1:0];
            end
        end
    end

    // One-hot grant and operand mux for the selected requester.
    always_comb begin
        grant_oh = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_oh[i] = any_req && (grant_idx == IDW'(i));
            if (grant_oh[i]) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
        ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Accept strobe only while idle and out of reset.
    assign req_ready = (state_q == IDLE && rst_n) ? grant_oh : '0;

    // Control FSM with registered datapath outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        mul_a_q   <= sel_a;
                        mul_b_q   <= sel_b;
                        resp_id_q <= grant_idx;
                        cnt_q     <= CNTW'(MUL_LATENCY);
                        ptr_q     <= ptr_d;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        resp_data_q  <= mul_op;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_valid = resp_valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// tb_fpu_mul_arbiter: two instances (latency 0 and 3) driven with directed and
// randomized requests, checked against a round-robin / FP32 reference model.
module tb_fpu_mul_arbiter;

    localparam int N = 4;
    localparam logic [31:0] VALS [8] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'hC0000000,
                                         32'h3F000000, 32'h3FA00000, 32'h3F400000, 32'h40800000};

    logic         clk = 1'b0;
    logic         rst_n      [2];
    logic [N-1:0] req_valid  [2];
    logic [N-1:0] req_ready  [2];
    logic [127:0] req_a      [2];
    logic [127:0] req_b      [2];
    logic         resp_valid [2];
    logic         resp_ready [2];
    logic [1:0]   resp_id    [2];
    logic [31:0]  resp_data  [2];
    logic [31:0]  mul_a      [2];
    logic [31:0]  mul_b      [2];
    logic [31:0]  mul_op     [2];
    logic         busy       [2];

    // Reference model state
    logic [N-1:0] pending [2];
    logic [31:0]  opa [2][N];
    logic [31:0]  opb [2][N];
    int           mptr [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // FP32 multiply for normal operands whose product is exact.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (p[47]) begin
            e = e + 10'd1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    assign mul_op[0] = fmul(mul_a[0], mul_b[0]);
    assign mul_op[1] = fmul(mul_a[1], mul_b[1]);

    fpu_mul_arbiter #(.NREQ(N), .IDW(2), .MUL_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a[0]), .req_b(req_b[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_id(resp_id[0]), .resp_data(resp_data[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_op(mul_op[0]),
        .busy(busy[0])
    );

    fpu_mul_arbiter #(.NREQ(N), .IDW(2), .MUL_LATENCY(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a[1]), .req_b(req_b[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_id(resp_id[1]), .resp_data(resp_data[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_op(mul_op[1]),
        .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input int u);
        req_valid[u] = pending[u];
        for (int i = 0; i < N; i++) begin
            req_a[u][32*i +: 32] = opa[u][i];
            req_b[u][32*i +: 32] = opb[u][i];
        end
    endtask

    function automatic int exp_grant(input int u);
        for (int k = 0; k < N; k++) begin
            if (pending[u][(mptr[u] + k) % N]) return (mptr[u] + k) % N;
        end
        return 0;
    endfunction

    task automatic check_reset(input int u);
        check("rst_req_ready", 32'(req_ready[u]), 32'd0);
        check("rst_resp_valid", 32'(resp_valid[u]), 32'd0);
        check("rst_resp_id", 32'(resp_id[u]), 32'd0);
        check("rst_resp_data", resp_data[u], 32'd0);
        check("rst_mul_a", mul_a[u], 32'd0);
        check("rst_mul_b", mul_b[u], 32'd0);
        check("rst_busy", 32'(busy[u]), 32'd0);
    endtask

    // One full transaction: grant, execute, respond (with optional stall), handshake.
    task automatic do_op(input int u, input int stall, output logic [31:0] got_data, output int got_id);
        int           g;
        int           cyc;
        bit           seen;
        logic [N-1:0] oh;
        logic [31:0]  ea, eb, prod;
        int           lat;
        lat = (u == 0) ? 0 : 3;
        apply(u);
        #1;
        g  = exp_grant(u);
        oh = '0;
        oh[g] = 1'b1;
        check("grant_onehot", 32'(req_ready[u]), 32'(oh));
        check("busy_idle", 32'(busy[u]), 32'd0);
        ea   = opa[u][g];
        eb   = opb[u][g];
        prod = fmul(ea, eb);
        @(posedge clk);
        #1;
        pending[u][g] = 1'b0;
        mptr[u] = (g + 1) % N;
        opa[u][g] = VALS[$urandom_range(0, 7)];
        opb[u][g] = VALS[$urandom_range(0, 7)];
        apply(u);
        check("mul_a", mul_a[u], ea);
        check("mul_b", mul_b[u], eb);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            check("ready_exec", 32'(req_ready[u]), 32'd0);
            @(posedge clk);
            cyc++;
            #1;
            seen = resp_valid[u];
        end
        check("latency", 32'(cyc), 32'(lat + 1));
        check("resp_id", 32'(resp_id[u]), 32'(g));
        check("resp_data", resp_data[u], prod);
        check("busy_resp", 32'(busy[u]), 32'd1);
        for (int s = 0; s < stall; s++) begin
            req_valid[u] = pending[u] | 4'($urandom_range(0, 15));
            #1;
            check("stall_ready", 32'(req_ready[u]), 32'd0);
            check("stall_valid", 32'(resp_valid[u]), 32'd1);
            check("stall_data", resp_data[u], prod);
            check("stall_id", 32'(resp_id[u]), 32'(g));
            @(posedge clk);
            #1;
        end
        apply(u);
        resp_ready[u] = 1'b1;
        #1;
        check("ready_resp", 32'(req_ready[u]), 32'd0);
        got_data = resp_data[u];
        got_id   = int'(resp_id[u]);
        @(posedge clk);
        #1;
        resp_ready[u] = 1'b0;
        check("valid_after_hs", 32'(resp_valid[u]), 32'd0);
        check("busy_after_hs", 32'(busy[u]), 32'd0);
    endtask

    task automatic randomize_ops(input int u);
        for (int i = 0; i < N; i++) begin
            opa[u][i] = VALS[$urandom_range(0, 7)];
            opb[u][i] = VALS[$urandom_range(0, 7)];
        end
        pending[u] = pending[u] | 4'($urandom_range(1, 15));
    endtask

    initial begin
        logic [31:0] d;
        int          id;
        int          start;
        for (int u = 0; u < 2; u++) begin
            rst_n[u]      = 1'b0;
            resp_ready[u] = 1'b0;
            pending[u]    = '0;
            mptr[u]       = 0;
            for (int i = 0; i < N; i++) begin
                opa[u][i] = VALS[i];
                opb[u][i] = VALS[i + 1];
            end
            apply(u);
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        req_valid[0] = 4'hF;
        #1;
        check("rst_ready_with_valid", 32'(req_ready[0]), 32'd0);
        apply(0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);

        // 2.0 * 3.0 from requester 0
        opa[0][0] = 32'h40000000;
        opb[0][0] = 32'h40400000;
        pending[0] = 4'b0001;
        do_op(0, 0, d, id);
        check("t1_data", d, 32'h40C00000);
        check("t1_id", 32'(id), 32'd0);

        // -2.0 * 0.5 held for 10 cycles of back-pressure
        opa[0][0] = 32'hC0000000;
        opb[0][0] = 32'h3F000000;
        pending[0] = 4'b0001;
        do_op(0, 10, d, id);
        check("t3_data", d, 32'hBF800000);

        // All requesters valid: strict rotation
        opa[0][0] = 32'h3FC00000; opb[0][0] = 32'h3FC00000;
        opa[0][1] = 32'h3FC00000; opb[0][1] = 32'h40000000;
        opa[0][2] = 32'h3FC00000; opb[0][2] = 32'h40400000;
        opa[0][3] = 32'h3FC00000; opb[0][3] = 32'h3F000000;
        start = mptr[0];
        for (int k = 0; k < 5; k++) begin
            logic [31:0] ea, eb;
            pending[0] = 4'hF;
            ea = opa[0][(start + k) % N];
            eb = opb[0][(start + k) % N];
            do_op(0, 0, d, id);
            check("t2_order", 32'(id), 32'((start + k) % N));
            if (ea == 32'h3FC00000 && eb == 32'h3FC00000) check("t2_2p25", d, 32'h40100000);
            opa[0][id] = ea;
            opb[0][id] = eb;
        end

        // Single requester 2 with wrap of the pointer
        pending[0] = 4'b0100;
        do_op(0, 0, d, id);
        check("t6_first", 32'(id), 32'd2);
        pending[0] = 4'b0100;
        do_op(0, 1, d, id);
        check("t6_wrap", 32'(id), 32'd2);
        pending[0] = 4'hF;
        do_op(0, 0, d, id);
        check("t6_ptr3", 32'(id), 32'd3);

        // Randomized traffic, latency 0
        for (int n = 0; n < 30; n++) begin
            randomize_ops(0);
            do_op(0, $urandom_range(0, 3), d, id);
        end

        // Randomized traffic, latency 3
        for (int n = 0; n < 20; n++) begin
            randomize_ops(1);
            do_op(1, $urandom_range(0, 3), d, id);
        end

        // Reset in the middle of EXEC: operation discarded
        pending[1] = 4'b0100;
        apply(1);
        #1;
        check("t4_grant", 32'(req_ready[1]), 32'(4'b0100));
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        check("t4_busy_exec", 32'(busy[1]), 32'd1);
        rst_n[1] = 1'b0;
        #1;
        check_reset(1);
        pending[1] = '0;
        mptr[1] = 0;
        apply(1);
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("t4_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        pending[1] = 4'hF;
        do_op(1, 0, d, id);
        check("t4_ptr_reset", 32'(id), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
